// File: rtl/pwm_carrier_event_gen_if.sv
// Configuration and status bundle between the PWM register file / channel logic
// and the carrier event generator.
interface pwm_carrier_event_gen_if #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 4
);
  logic             pwm_on;
  logic [1:0]       carrier_mode;
  logic [CNT_W-1:0] period;
  logic [1:0]       mask_sel;
  logic [PSC_W-1:0] mask_prescale;
  logic [CNT_W-1:0] count_out;
  logic             count_dir;
  logic             zero_event;
  logic             period_event;
  logic             mask_event;

  modport master (
    output pwm_on, carrier_mode, period, mask_sel, mask_prescale,
    input  count_out, count_dir, zero_event, period_event, mask_event
  );

  modport slave (
    input  pwm_on, carrier_mode, period, mask_sel, mask_prescale,
    output count_out, count_dir, zero_event, period_event, mask_event
  );
endinterface

// File: rtl/pwm_carrier_event_gen.sv
// PWM carrier counter with zero/period boundary flags and a prescaled
// mask_event strobe that times shadow-register loads in each PWM channel.
module pwm_carrier_event_gen #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  pwm_carrier_event_gen_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_UPDOWN = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e            mode;
  logic [CNT_W-1:0] count_q, count_d, start_cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             dir_q, dir_d, start_dir;
  logic             run_q, run_d;
  logic             zero_q, zero_d;
  logic             per_q, per_d;
  logic             mask_q, mask_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             qual;

  assign mode      = mode_e'(bus.carrier_mode);
  assign start_cnt = (mode == MODE_DOWN) ? bus.period : '0;
  assign start_dir = (mode != MODE_DOWN);
  // One extra bit so count+1 is compared against period without wrapping.
  assign cnt_inc   = {1'b0, count_q} + (CNT_W + 1)'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    count_d = count_q;
    dir_d   = dir_q;
    psc_d   = psc_q;
    run_d   = bus.pwm_on;
    zero_d  = 1'b0;
    per_d   = 1'b0;
    mask_d  = 1'b0;
    qual    = 1'b0;

    if (!bus.pwm_on) begin
      count_d = start_cnt;
      dir_d   = start_dir;
      psc_d   = '0;
    end else if (mode != MODE_HOLD) begin
      if (!run_q) begin
        // First running cycle re-presents the start value so its events fire.
        count_d = start_cnt;
        dir_d   = start_dir;
      end else begin
        case (mode)
          MODE_UP: begin
            dir_d   = 1'b1;
            count_d = (count_q >= bus.period) ? '0 : cnt_inc[CNT_W-1:0];
          end
          MODE_DOWN: begin
            dir_d   = 1'b0;
            count_d = (count_q == '0) ? bus.period : count_q - CNT_W'(1);
          end
          MODE_UPDOWN: begin
            if (dir_q) begin
              if (cnt_inc >= {1'b0, bus.period}) begin
                count_d = bus.period;
                dir_d   = 1'b0;
              end else begin
                count_d = cnt_inc[CNT_W-1:0];
              end
            end else if (count_q <= CNT_W'(1)) begin
              count_d = '0;
              dir_d   = 1'b1;
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end

      zero_d = (count_d == '0);
      per_d  = (count_d == bus.period);
      qual   = (bus.mask_sel[0] && zero_d) || (bus.mask_sel[1] && per_d);
      if (qual) begin
        // >= so a prescale lowered below the current count still fires.
        if (psc_q >= bus.mask_prescale) begin
          mask_d = 1'b1;
          psc_d  = '0;
        end else begin
          psc_d  = psc_q + PSC_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      run_q   <= 1'b0;
      zero_q  <= 1'b0;
      per_q   <= 1'b0;
      mask_q  <= 1'b0;
      psc_q   <= '0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      zero_q  <= zero_d;
      per_q   <= per_d;
      mask_q  <= mask_d;
      psc_q   <= psc_d;
    end
  end

  assign bus.count_out    = count_q;
  assign bus.count_dir    = dir_q;
  assign bus.zero_event   = zero_q;
  assign bus.period_event = per_q;
  assign bus.mask_event   = mask_q;

endmodule

// File: tb/tb_pwm_carrier_event_gen.sv
// Directed bench for pwm_carrier_event_gen: each task drives one scenario and
// compares {count_out, count_dir, zero_event, period_event, mask_event}.
module tb_pwm_carrier_event_gen;
  localparam int CNT_W = 16;
  localparam int PSC_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pwm_carrier_event_gen_if #(.CNT_W(CNT_W), .PSC_W(PSC_W)) bus ();

  pwm_carrier_event_gen #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Sample 1 ns after the rising edge; inputs are also changed there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] snap();
    return {bus.count_out, bus.count_dir, bus.zero_event, bus.period_event, bus.mask_event};
  endfunction

  // Expected word: count plus flags {dir, zero, period, mask}.
  function automatic logic [19:0] ev(int c, logic [3:0] f);
    return {c[15:0], f};
  endfunction

  task automatic configure(logic on, logic [1:0] mode, int per, logic [1:0] sel, int psc);
    bus.pwm_on        = on;
    bus.carrier_mode  = mode;
    bus.period        = per[15:0];
    bus.mask_sel      = sel;
    bus.mask_prescale = psc[3:0];
  endtask

  task automatic test_reset();
    logic [19:0] got;
    configure(1'b0, 2'b00, 5, 2'b01, 0);
    reset = 1'b1;
    tick();
    got = snap(); total++;
    if (got !== ev(0, 4'b1000)) begin
      bad++;
      $display("FAIL reset_state: got cnt=%0d flags=%b want cnt=0 flags=1000", got[19:4], got[3:0]);
    end
    reset = 1'b0;
    bus.pwm_on = 1'b1;
    repeat (3) tick();
    got = snap(); total++;
    if (got !== ev(2, 4'b1000)) begin
      bad++;
      $display("FAIL reset_prerun: got cnt=%0d flags=%b want cnt=2 flags=1000", got[19:4], got[3:0]);
    end
    #2 reset = 1'b1;
    #1;
    got = snap(); total++;
    if (got !== ev(0, 4'b1000)) begin
      bad++;
      $display("FAIL reset_async: got cnt=%0d flags=%b want cnt=0 flags=1000", got[19:4], got[3:0]);
    end
    configure(1'b0, 2'b01, 9, 2'b11, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = snap(); total++;
      if (got !== ev(9, 4'b0000)) begin
        bad++;
        $display("FAIL idle_down[%0d]: got cnt=%0d flags=%b want cnt=9 flags=0000", i, got[19:4], got[3:0]);
      end
    end
  endtask

  task automatic test_up();
    logic [19:0] got;
    logic [19:0] exp_t [7];
    exp_t = '{ev(0, 4'b1101), ev(1, 4'b1000), ev(2, 4'b1000), ev(3, 4'b1000),
              ev(4, 4'b1010), ev(0, 4'b1101), ev(1, 4'b1000)};
    configure(1'b0, 2'b00, 4, 2'b01, 0);
    tick();
    bus.pwm_on = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      got = snap(); total++;
      if (got !== exp_t[i]) begin
        bad++;
        $display("FAIL up[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b",
                 i, got[19:4], got[3:0], exp_t[i][19:4], exp_t[i][3:0]);
      end
    end
  endtask

  task automatic test_updown_prescale();
    logic [19:0] got;
    logic [19:0] exp_t [14];
    exp_t = '{ev(0, 4'b1100), ev(1, 4'b1000), ev(2, 4'b1000), ev(3, 4'b0010),
              ev(2, 4'b0000), ev(1, 4'b0000), ev(0, 4'b1101), ev(1, 4'b1000),
              ev(2, 4'b1000), ev(3, 4'b0010), ev(2, 4'b0000), ev(1, 4'b0000),
              ev(0, 4'b1100), ev(1, 4'b1000)};
    configure(1'b0, 2'b10, 3, 2'b11, 2);
    tick();
    bus.pwm_on = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      got = snap(); total++;
      if (got !== exp_t[i]) begin
        bad++;
        $display("FAIL updown[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b",
                 i, got[19:4], got[3:0], exp_t[i][19:4], exp_t[i][3:0]);
      end
    end
  endtask

  task automatic test_period_shrink();
    logic [19:0] got;
    logic [19:0] exp_t [6];
    exp_t = '{ev(7, 4'b1000), ev(0, 4'b1100), ev(1, 4'b1000),
              ev(7, 4'b1000), ev(5, 4'b0010), ev(4, 4'b0000)};
    for (int m = 0; m < 2; m++) begin
      configure(1'b0, (m == 0) ? 2'b00 : 2'b10, 10, 2'b00, 0);
      tick();
      bus.pwm_on = 1'b1;
      repeat (8) tick();
      for (int i = 0; i < 3; i++) begin
        if (i == 1) begin
          bus.period = 16'd5;
          tick();
        end else if (i == 2) begin
          tick();
        end
        got = snap(); total++;
        if (got !== exp_t[m*3+i]) begin
          bad++;
          $display("FAIL shrink[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b",
                   m*3+i, got[19:4], got[3:0], exp_t[m*3+i][19:4], exp_t[m*3+i][3:0]);
        end
      end
    end
  endtask

  task automatic test_period_zero();
    logic [19:0] got;
    logic [19:0] want;
    configure(1'b0, 2'b00, 0, 2'b11, 1);
    tick();
    bus.pwm_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      want = ev(0, {3'b111, (i % 2 == 1)});
      got = snap(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL pzero_up[%0d]: got cnt=%0d flags=%b want cnt=0 flags=%b", i, got[19:4], got[3:0], want[3:0]);
      end
    end
    configure(1'b0, 2'b01, 0, 2'b11, 0);
    tick();
    bus.pwm_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = snap(); total++;
      if (got !== ev(0, 4'b0111)) begin
        bad++;
        $display("FAIL pzero_down[%0d]: got cnt=%0d flags=%b want cnt=0 flags=0111", i, got[19:4], got[3:0]);
      end
    end
  endtask

  task automatic test_hold_off();
    logic [19:0] got;
    logic [19:0] exp_t [13];
    int          k;
    exp_t = '{ev(0, 4'b1100), ev(6, 4'b1000), ev(6, 4'b1000), ev(6, 4'b1000),
              ev(6, 4'b1000), ev(10, 4'b1010), ev(0, 4'b1101), ev(0, 4'b1100),
              ev(1, 4'b1000), ev(0, 4'b1000), ev(0, 4'b1100), ev(10, 4'b1010),
              ev(0, 4'b1101)};
    k = 0;
    configure(1'b0, 2'b00, 10, 2'b01, 1);
    tick();
    bus.pwm_on = 1'b1;
    for (int i = 0; i < 13; i++) begin
      case (i)
        0:       tick();
        1:       repeat (6) tick();
        2:       begin bus.carrier_mode = 2'b11; tick(); end
        3, 4:    tick();
        5:       begin bus.carrier_mode = 2'b00; repeat (4) tick(); end
        6:       tick();
        7:       repeat (11) tick();
        8:       tick();
        9:       begin bus.pwm_on = 1'b0; tick(); end
        10:      begin bus.pwm_on = 1'b1; tick(); end
        11:      repeat (10) tick();
        default: tick();
      endcase
      got = snap(); total++;
      if (got !== exp_t[i]) begin
        bad++;
        $display("FAIL hold_off[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b",
                 i, got[19:4], got[3:0], exp_t[i][19:4], exp_t[i][3:0]);
      end
      k++;
    end
    total++;
    if (k != 13) begin
      bad++;
      $display("FAIL hold_off_steps: got %0d want 13", k);
    end
  endtask

  initial begin
    reset = 1'b1;
    configure(1'b0, 2'b00, 0, 2'b00, 0);
    test_reset();
    test_up();
    test_updown_prescale();
    test_period_shrink();
    test_period_zero();
    test_hold_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
